// File: rtl/dvs_ravens_pkg.sv
// Shared RAVENS packet definitions for the dvs_ravens datapath.
package dvs_ravens_pkg;

   localparam int unsigned RAVENS_PKT_BITS = 32;

endpackage

// File: rtl/ravens_spike_arbiter.sv
// Merges spike packets from two DVS channels through per-source FIFOs onto a
// single registered valid/ready stream using round-robin arbitration.
module ravens_spike_arbiter
   import dvs_ravens_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH         = 4,
   parameter logic [7:0]  SRC1_NEURON_OFFSET = 8'd100,
   parameter int unsigned DROP_CNT_W         = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [RAVENS_PKT_BITS-1:0] in0_pkt,
   input  logic                       in0_valid,
   input  logic [RAVENS_PKT_BITS-1:0] in1_pkt,
   input  logic                       in1_valid,
   output logic [RAVENS_PKT_BITS-1:0] out_pkt,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DROP_CNT_W-1:0]      drop_cnt0,
   output logic [DROP_CNT_W-1:0]      drop_cnt1
);

   localparam int unsigned PW = RAVENS_PKT_BITS;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [2:0]  OP_SPIKE = 3'b000;

   logic [PW-1:0] mem0 [FIFO_DEPTH];
   logic [PW-1:0] mem1 [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
   logic [CW-1:0] count0, count1;
   logic          last_grant;

   logic          spike0_c, spike1_c;
   logic [PW-1:0] pkt1_mod_c;
   logic          empty0_c, empty1_c;
   logic          load_en_c;
   logic          grant_c;
   logic          pop0_c, pop1_c;
   logic          wr0_c, wr1_c;
   logic          drop0_c, drop1_c;

   // Spike qualification and source 1 neuron remap (8-bit add wraps mod 256).
   always_comb begin
      spike0_c   = in0_valid && (in0_pkt[PW-1 -: 3] == OP_SPIKE);
      spike1_c   = in1_valid && (in1_pkt[PW-1 -: 3] == OP_SPIKE);
      pkt1_mod_c = in1_pkt;
      pkt1_mod_c[12:5] = in1_pkt[12:5] + SRC1_NEURON_OFFSET;
   end

   // Round-robin grant, pop and write/drop decisions.
   always_comb begin
      empty0_c  = (count0 == '0);
      empty1_c  = (count1 == '0);
      load_en_c = !out_valid || out_ready;
      grant_c   = 1'b0;
      if (!empty0_c && !empty1_c) begin
         grant_c = ~last_grant;
      end else if (!empty1_c) begin
         grant_c = 1'b1;
      end
      pop0_c  = load_en_c && !empty0_c && !grant_c;
      pop1_c  = load_en_c && !empty1_c && grant_c;
      wr0_c   = spike0_c && ((count0 < CW'(FIFO_DEPTH)) || pop0_c);
      wr1_c   = spike1_c && ((count1 < CW'(FIFO_DEPTH)) || pop1_c);
      drop0_c = spike0_c && !wr0_c;
      drop1_c = spike1_c && !wr1_c;
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (wr0_c) mem0[wr_ptr0] <= in0_pkt;
      if (wr1_c) mem1[wr_ptr1] <= pkt1_mod_c;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr0 <= '0;
         rd_ptr0 <= '0;
         count0  <= '0;
         wr_ptr1 <= '0;
         rd_ptr1 <= '0;
         count1  <= '0;
      end else begin
         if (wr0_c)  wr_ptr0 <= wr_ptr0 + AW'(1);
         if (pop0_c) rd_ptr0 <= rd_ptr0 + AW'(1);
         count0 <= count0 + CW'(wr0_c) - CW'(pop0_c);
         if (wr1_c)  wr_ptr1 <= wr_ptr1 + AW'(1);
         if (pop1_c) rd_ptr1 <= rd_ptr1 + AW'(1);
         count1 <= count1 + CW'(wr1_c) - CW'(pop1_c);
      end
   end

   // Arbitration history: remembers which source was popped last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (pop0_c) begin
         last_grant <= 1'b0;
      end else if (pop1_c) begin
         last_grant <= 1'b1;
      end
   end

   // Output register: reload when empty or consumed, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_pkt   <= '0;
         out_valid <= 1'b0;
      end else if (load_en_c) begin
         if (pop0_c) begin
            out_pkt   <= mem0[rd_ptr0];
            out_valid <= 1'b1;
         end else if (pop1_c) begin
            out_pkt   <= mem1[rd_ptr1];
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // Saturating drop counters for spikes refused by a full FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt0 <= '0;
         drop_cnt1 <= '0;
      end else begin
         if (drop0_c && (drop_cnt0 != '1)) drop_cnt0 <= drop_cnt0 + DROP_CNT_W'(1);
         if (drop1_c && (drop_cnt1 != '1)) drop_cnt1 <= drop_cnt1 + DROP_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ravens_spike_arbiter.sv
// Self-checking bench for ravens_spike_arbiter: vector table plus directed
// sequences, with a scoreboard queue checked on every output handshake.
module tb_ravens_spike_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in0_pkt, in1_pkt;
   logic        in0_valid, in1_valid;
   logic [31:0] out_pkt;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] drop_cnt0, drop_cnt1;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] sb [$];

   typedef struct {
      logic        src;
      logic [31:0] pkt;
      logic        accept;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs [7];

   ravens_spike_arbiter #(
      .FIFO_DEPTH(4),
      .SRC1_NEURON_OFFSET(8'd100),
      .DROP_CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in0_pkt(in0_pkt),
      .in0_valid(in0_valid),
      .in1_pkt(in1_pkt),
      .in1_valid(in1_valid),
      .out_pkt(out_pkt),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .drop_cnt0(drop_cnt0),
      .drop_cnt1(drop_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] n);
      logic [31:0] p;
      p = '0;
      p[31:29] = op;
      p[12:5] = n;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs are stable between negedge and the next posedge, so a
   // valid&ready seen here is exactly the handshake that edge completes.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", out_pkt, 32'hxxxx_xxxx);
         end else begin
            chk("scoreboard", out_pkt, sb.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] p [6];

      vecs[0] = '{1'b0, 32'h0000_0540, 1'b1, 32'h0000_0540};
      vecs[1] = '{1'b1, 32'h0000_1900, 1'b1, 32'h0000_0580};
      vecs[2] = '{1'b0, 32'h1234_5541, 1'b1, 32'h1234_5541};
      vecs[3] = '{1'b1, 32'h0ABC_DFFF, 1'b1, 32'h0ABC_CC7F};
      vecs[4] = '{1'b0, 32'h4000_0540, 1'b0, 32'h0000_0000};
      vecs[5] = '{1'b1, 32'hE000_0000, 1'b0, 32'h0000_0000};
      vecs[6] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0C80};

      rst = 1'b1;
      in0_pkt = '0; in1_pkt = '0; in0_valid = 1'b0; in1_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pkt", out_pkt, 32'd0);
      chk("rst_drop0", 32'(drop_cnt0), 32'd0);
      chk("rst_drop1", 32'(drop_cnt1), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Single-packet vectors with exact latency checks.
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].src) begin
            in1_pkt = vecs[i].pkt; in1_valid = 1'b1;
         end else begin
            in0_pkt = vecs[i].pkt; in0_valid = 1'b1;
         end
         if (vecs[i].accept) sb.push_back(vecs[i].exp_out);
         tick();
         in0_valid = 1'b0; in1_valid = 1'b0;
         chk($sformatf("v%0d_valid_k", i), 32'(out_valid), 32'd0);
         tick();
         chk($sformatf("v%0d_valid_k1", i), 32'(out_valid), 32'(vecs[i].accept));
         if (vecs[i].accept) chk($sformatf("v%0d_pkt", i), out_pkt, vecs[i].exp_out);
         tick();
         chk($sformatf("v%0d_valid_k2", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d_drop0", i), 32'(drop_cnt0), 32'd0);
         chk($sformatf("v%0d_drop1", i), 32'(drop_cnt1), 32'd0);
      end
      chk("vec_sb_empty", 32'(sb.size()), 32'd0);

      // Simultaneous sources alternate starting with source 0.
      for (int i = 0; i < 3; i++) begin
         in0_pkt = mk(3'b000, 8'(1 + i));  in0_valid = 1'b1;
         in1_pkt = mk(3'b000, 8'(10 + i)); in1_valid = 1'b1;
         sb.push_back(mk(3'b000, 8'(1 + i)));
         sb.push_back(mk(3'b000, 8'(110 + i)));
         tick();
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("alt_sb_empty", 32'(sb.size()), 32'd0);
      chk("alt_drop0", 32'(drop_cnt0), 32'd0);
      chk("alt_drop1", 32'(drop_cnt1), 32'd0);

      // Backpressure: p0 held, p1..p4 buffered, p5 dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         p[i] = mk(3'b000, 8'(8'h30 + i));
         in0_pkt = p[i]; in0_valid = 1'b1;
         if (i < 5) sb.push_back(p[i]);
         tick();
      end
      in0_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_pkt", out_pkt, p[0]);
         tick();
      end
      chk("bp_drop0", 32'(drop_cnt0), 32'd1);
      chk("bp_drop1", 32'(drop_cnt1), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_stream_valid", 32'(out_valid), 32'd1);
         tick();
      end
      chk("bp_sb_empty", 32'(sb.size()), 32'd0);
      chk("bp_idle", 32'(out_valid), 32'd0);

      // Reset mid-stream with packets buffered and a nonzero drop count.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in1_pkt = mk(3'b000, 8'(8'h40 + i)); in1_valid = 1'b1;
         tick();
      end
      in1_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_pkt", out_pkt, 32'd0);
      chk("mid_rst_drop0", 32'(drop_cnt0), 32'd0);
      chk("mid_rst_drop1", 32'(drop_cnt1), 32'd0);
      sb.delete();
      tick(); tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_idle", 32'(out_valid), 32'd0);
      end
      in0_pkt = mk(3'b000, 8'h55); in0_valid = 1'b1;
      sb.push_back(mk(3'b000, 8'h55));
      tick();
      in0_valid = 1'b0;
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_pkt", out_pkt, mk(3'b000, 8'h55));
      tick(); tick();
      chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
